// File: rtl/ms_wb_initiator.sv
// ms_wb_initiator: single-outstanding Wishbone classic bus master.
// Accepts one command on a valid/ready stream, runs one Wishbone cycle with
// an optional ack timeout, and returns the result on a valid/ready stream.
module ms_wb_initiator #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        busy,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    output logic [3:0]  sel_o,
    input  logic        ack_i,
    input  logic [31:0] dat_i
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    // Counter value seen in the last bus cycle before the timeout aborts.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] tmo_cnt;
    logic        tmo_hit;

    assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
    assign stb_o   = cyc_o;

    // State register; reset drops the bus cycle immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake/strobe decode; ack wins over the timeout.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        cyc_o     = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                cmd_ready = ~rst_i;
                if (cmd_valid && !rst_i) begin
                    state_nxt = BUS;
                end
            end
            BUS: begin
                cyc_o = 1'b1;
                if (ack_i || tmo_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Command capture, timeout counting and response capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_o    <= 1'b0;
            adr_o   <= '0;
            dat_o   <= '0;
            sel_o   <= '0;
            rsp_dat <= '0;
            rsp_err <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        we_o    <= cmd_we;
                        adr_o   <= cmd_adr;
                        dat_o   <= cmd_dat;
                        sel_o   <= cmd_sel;
                        tmo_cnt <= '0;
                    end
                end
                BUS: begin
                    if (ack_i) begin
                        rsp_dat <= we_o ? '0 : dat_i;
                        rsp_err <= 1'b0;
                    end else if (tmo_hit) begin
                        rsp_dat <= we_o ? '0 : ERR_DATA;
                        rsp_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ms_wb_initiator.sv
// Self-checking bench for ms_wb_initiator: behavioural slave plus a
// transaction-level reference memory.
module tb_ms_wb_initiator;

    localparam int unsigned TMO  = 8;
    localparam logic [31:0] ERRD = 32'hE11E0000;
    localparam logic [31:0] UNMAPPED_DATA = 32'hDEADBEEF;
    localparam logic [31:0] FORCED_DATA   = 32'hC01C1DE5;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        busy;
    logic        cyc_o, stb_o, we_o;
    logic [31:0] adr_o, dat_o;
    logic [3:0]  sel_o;
    logic        ack_i;
    logic [31:0] dat_i;

    logic        s_ack;
    logic        inj_ack = 1'b0;
    int          mode = 0;      // 0 registered-ack slave, 1 no ack, 2 ack in bus cycle forced_n
    int          forced_n = 8;
    int          bcnt;
    int          ack_cnt;
    logic [31:0] smem [16];
    logic [31:0] ref_mem [16];

    int checks = 0;
    int errors = 0;

    assign ack_i = s_ack | inj_ack;

    ms_wb_initiator #(.TIMEOUT(TMO), .ERR_DATA(ERRD)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_err(rsp_err), .busy(busy),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
        .dat_o(dat_o), .sel_o(sel_o), .ack_i(ack_i), .dat_i(dat_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural peripheral: 16 words at 0x00..0x3C, registered ack.
    always @(posedge clk_i) begin
        bcnt <= cyc_o ? bcnt + 1 : 0;
        if (cyc_o && ack_i) ack_cnt <= ack_cnt + 1;
        if (rst_i) begin
            s_ack <= 1'b0;
            dat_i <= '0;
            for (int i = 0; i < 16; i++) smem[i] <= '0;
        end else if (mode == 0) begin
            s_ack <= cyc_o & stb_o & ~s_ack;
            if (cyc_o && stb_o && !s_ack) begin
                if (adr_o[31:6] == '0) begin
                    if (we_o) begin
                        for (int b = 0; b < 4; b++)
                            if (sel_o[b]) smem[adr_o[5:2]][8*b +: 8] <= dat_o[8*b +: 8];
                    end else begin
                        dat_i <= smem[adr_o[5:2]];
                    end
                end else begin
                    dat_i <= UNMAPPED_DATA;
                end
            end
        end else if (mode == 1) begin
            s_ack <= 1'b0;
        end else begin
            s_ack <= cyc_o && (bcnt == forced_n - 2);
            dat_i <= FORCED_DATA;
        end
    end

    initial begin
        bcnt = 0;
        ack_cnt = 0;
    end

    // Runs one command through the DUT, checking bus hold, response stability
    // during the stall and the return to IDLE; reports response and timing.
    task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int stall, input logic poke,
                          output logic [31:0] rdat, output logic rerr,
                          output int lat, output int ncyc, output int nack);
        int guard;
        int a0;
        @(negedge clk_i);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk_i);
            guard++;
        end
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL accept: cmd_ready=%0b required 1", cmd_ready);
        end
        @(negedge clk_i);
        a0 = ack_cnt;
        cmd_valid = 1'b0; cmd_adr = $urandom; cmd_dat = $urandom; cmd_we = ~we;
        checks++;
        if ({cyc_o, stb_o, we_o, adr_o, dat_o, sel_o, busy, cmd_ready} !==
            {1'b1, 1'b1, we, adr, dat, sel, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL bus_hold: cyc=%0b stb=%0b we=%0b adr=%h dat=%h sel=%h busy=%0b rdy=%0b required 1 1 %0b %h %h %h 1 0",
                     cyc_o, stb_o, we_o, adr_o, dat_o, sel_o, busy, cmd_ready, we, adr, dat, sel);
        end
        lat = 1; ncyc = 0;
        while (!rsp_valid && lat < 300) begin
            if (cyc_o) ncyc++;
            @(negedge clk_i);
            lat++;
        end
        lat--;
        nack = ack_cnt - a0;
        rdat = rsp_dat;
        rerr = rsp_err;
        checks++;
        if (rsp_valid !== 1'b1 || cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL response_arrival: rsp_valid=%0b cyc=%0b required 1 0", rsp_valid, cyc_o);
        end
        for (int i = 0; i < stall; i++) begin
            inj_ack = poke;
            @(negedge clk_i);
            checks++;
            if ({rsp_valid, rsp_dat, rsp_err, cmd_ready, cyc_o} !== {1'b1, rdat, rerr, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold: valid=%0b dat=%h err=%0b rdy=%0b cyc=%0b required 1 %h %0b 0 0",
                         rsp_valid, rsp_dat, rsp_err, cmd_ready, cyc_o, rdat, rerr);
            end
        end
        inj_ack = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk_i);
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready, busy, cyc_o} !== 4'b0100) begin
            errors++;
            $display("FAIL release: valid=%0b rdy=%0b busy=%0b cyc=%0b required 0 1 0 0",
                     rsp_valid, cmd_ready, busy, cyc_o);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_i);
        checks++;
        if ({cmd_ready, rsp_valid, rsp_err, rsp_dat, busy, cyc_o, stb_o, we_o, adr_o, dat_o, sel_o} !== '0) begin
            errors++;
            $display("FAIL reset_values: rdy=%0b valid=%0b err=%0b dat=%h busy=%0b cyc=%0b stb=%0b we=%0b adr=%h wdat=%h sel=%h required all 0",
                     cmd_ready, rsp_valid, rsp_err, rsp_dat, busy, cyc_o, stb_o, we_o, adr_o, dat_o, sel_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({cmd_ready, busy, cyc_o} !== 3'b100) begin
            errors++;
            $display("FAIL reset_release: rdy=%0b busy=%0b cyc=%0b required 1 0 0", cmd_ready, busy, cyc_o);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] d; logic e; int lat, nc, na;
        mode = 0;
        do_txn(1'b1, 32'h04, 32'h00001234, 4'hF, 0, 1'b0, d, e, lat, nc, na);
        ref_mem[1] = 32'h00001234;
        checks++;
        if (d !== '0 || e !== 1'b0 || lat != 2 || nc != 2 || na != 1) begin
            errors++;
            $display("FAIL write: dat=%h err=%0b lat=%0d cyc=%0d acks=%0d required 0 0 2 2 1", d, e, lat, nc, na);
        end
        do_txn(1'b0, 32'h04, 32'h0, 4'hF, 0, 1'b0, d, e, lat, nc, na);
        checks++;
        if (d !== 32'h00001234 || e !== 1'b0 || lat != 2 || nc != 2 || na != 1) begin
            errors++;
            $display("FAIL read_back: dat=%h err=%0b lat=%0d cyc=%0d acks=%0d required 00001234 0 2 2 1", d, e, lat, nc, na);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] d; logic e; int lat, nc, na;
        mode = 0;
        do_txn(1'b0, 32'h0300, 32'h0, 4'hF, 0, 1'b0, d, e, lat, nc, na);
        checks++;
        if (d !== UNMAPPED_DATA || e !== 1'b0) begin
            errors++;
            $display("FAIL unmapped_read: dat=%h err=%0b required %h 0", d, e, UNMAPPED_DATA);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] d; logic e; int lat, nc, na;
        mode = 1;
        do_txn(1'b0, 32'h08, 32'h0, 4'hF, 0, 1'b0, d, e, lat, nc, na);
        checks++;
        if (d !== ERRD || e !== 1'b1 || nc != TMO || lat != TMO) begin
            errors++;
            $display("FAIL timeout_read: dat=%h err=%0b cyc=%0d lat=%0d required %h 1 %0d %0d", d, e, nc, lat, ERRD, TMO, TMO);
        end
        do_txn(1'b1, 32'h08, 32'h5555AAAA, 4'hF, 0, 1'b0, d, e, lat, nc, na);
        checks++;
        if (d !== '0 || e !== 1'b1 || nc != TMO) begin
            errors++;
            $display("FAIL timeout_write: dat=%h err=%0b cyc=%0d required 0 1 %0d", d, e, nc, TMO);
        end
        // late ack arriving while idle must be discarded
        @(negedge clk_i);
        inj_ack = 1'b1;
        repeat (2) @(negedge clk_i);
        inj_ack = 1'b0;
        checks++;
        if ({rsp_valid, busy, cyc_o, cmd_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL late_ack: valid=%0b busy=%0b cyc=%0b rdy=%0b required 0 0 0 1", rsp_valid, busy, cyc_o, cmd_ready);
        end
        mode = 0;
        do_txn(1'b0, 32'h04, 32'h0, 4'hF, 0, 1'b0, d, e, lat, nc, na);
        checks++;
        if (d !== ref_mem[1] || e !== 1'b0) begin
            errors++;
            $display("FAIL after_timeout_read: dat=%h err=%0b required %h 0", d, e, ref_mem[1]);
        end
    endtask

    task automatic test_ack_at_terminal();
        logic [31:0] d; logic e; int lat, nc, na;
        mode = 2; forced_n = TMO;
        do_txn(1'b0, 32'h0C, 32'h0, 4'hF, 0, 1'b0, d, e, lat, nc, na);
        checks++;
        if (d !== FORCED_DATA || e !== 1'b0 || nc != TMO || na != 1) begin
            errors++;
            $display("FAIL ack_at_terminal: dat=%h err=%0b cyc=%0d acks=%0d required %h 0 %0d 1", d, e, nc, na, FORCED_DATA, TMO);
        end
        forced_n = 3;
        do_txn(1'b0, 32'h0C, 32'h0, 4'hF, 0, 1'b0, d, e, lat, nc, na);
        checks++;
        if (d !== FORCED_DATA || e !== 1'b0 || nc != 3 || lat != 3) begin
            errors++;
            $display("FAIL ack_wait3: dat=%h err=%0b cyc=%0d lat=%0d required %h 0 3 3", d, e, nc, lat, FORCED_DATA);
        end
        mode = 0;
    endtask

    task automatic test_backpressure();
        logic [31:0] d; logic e; int lat, nc, na;
        mode = 0;
        do_txn(1'b1, 32'h20, 32'hA5A5F00D, 4'hF, 10, 1'b1, d, e, lat, nc, na);
        ref_mem[8] = 32'hA5A5F00D;
        do_txn(1'b0, 32'h20, 32'h0, 4'hF, 10, 1'b1, d, e, lat, nc, na);
        checks++;
        if (d !== 32'hA5A5F00D || e !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_read: dat=%h err=%0b required a5a5f00d 0", d, e);
        end
    endtask

    task automatic test_random();
        logic [31:0] d, adr, wd, exp_d; logic e, we, exp_e, mapped; logic [3:0] sel, idx;
        int lat, nc, na, exp_lat, exp_ack;
        for (int t = 0; t < 60; t++) begin
            we  = 1'($urandom_range(0, 1));
            idx = 4'($urandom_range(0, 15));
            mapped = ($urandom_range(0, 4) != 0);
            adr = mapped ? {26'd0, idx, 2'b00} : 32'h300 + 32'(idx) * 4;
            wd  = $urandom;
            sel = 4'($urandom_range(0, 15));
            mode = ($urandom_range(0, 5) == 0) ? 1 : 0;
            if (mode == 1) begin
                exp_e = 1'b1; exp_d = we ? '0 : ERRD; exp_lat = TMO; exp_ack = 0;
            end else begin
                exp_e = 1'b0; exp_lat = 2; exp_ack = 1;
                exp_d = we ? '0 : (mapped ? ref_mem[idx] : UNMAPPED_DATA);
                if (we && mapped)
                    for (int b = 0; b < 4; b++)
                        if (sel[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
            end
            do_txn(we, adr, wd, sel, $urandom_range(0, 2), 1'b0, d, e, lat, nc, na);
            checks++;
            if (d !== exp_d || e !== exp_e || lat != exp_lat || na != exp_ack) begin
                errors++;
                $display("FAIL random[%0d]: dat=%h err=%0b lat=%0d acks=%0d required %h %0b %0d %0d",
                         t, d, e, lat, na, exp_d, exp_e, exp_lat, exp_ack);
            end
        end
        mode = 0;
    endtask

    task automatic test_reset_during_bus();
        logic [31:0] d; logic e; int lat, nc, na;
        mode = 1;
        @(negedge clk_i);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h10; cmd_sel = 4'hF;
        @(negedge clk_i);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++;
        if (cyc_o !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_bus: cyc=%0b required 1", cyc_o);
        end
        #1 rst_i = 1'b1;
        #1;
        checks++;
        if ({cyc_o, stb_o, busy, rsp_valid, cmd_ready} !== 5'b00000) begin
            errors++;
            $display("FAIL async_reset: cyc=%0b stb=%0b busy=%0b valid=%0b rdy=%0b required 0 0 0 0 0",
                     cyc_o, stb_o, busy, rsp_valid, cmd_ready);
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        mode = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        do_txn(1'b1, 32'h10, 32'hFEEDF00D, 4'b0101, 0, 1'b0, d, e, lat, nc, na);
        checks++;
        if (d !== '0 || e !== 1'b0 || lat != 2) begin
            errors++;
            $display("FAIL post_reset_write: dat=%h err=%0b lat=%0d required 0 0 2", d, e, lat);
        end
        do_txn(1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0, d, e, lat, nc, na);
        checks++;
        if (d !== 32'h00ED000D || e !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_read: dat=%h err=%0b required 00ed000d 0", d, e);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        test_reset();
        test_write_read();
        test_unmapped();
        test_timeout();
        test_ack_at_terminal();
        test_backpressure();
        test_random();
        test_reset_during_bus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
